// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo definitions: tag geometry, unit IDs, multiply op codes and
// common-data-bus field layout.
package tomasulo_pkg;

  localparam int TAG_W     = 8;
  localparam int UNIT_ID_W = 5;
  // Low tag bits carry the reservation-station entry index plus one.
  localparam int IDX_W     = TAG_W - UNIT_ID_W;

  localparam logic [UNIT_ID_W-1:0] UID_ALU = 5'b00100;
  localparam logic [UNIT_ID_W-1:0] UID_MUL = 5'b01000;
  localparam logic [UNIT_ID_W-1:0] UID_LSU = 5'b01100;

  // 2'b11 is decoded as a plain low-half multiply.
  typedef enum logic [1:0] {
    OP_MUL   = 2'b00,
    OP_MULH  = 2'b01,
    OP_MULHU = 2'b10,
    OP_MULX  = 2'b11
  } mul_op_e;

  // Metadata that travels with each product through the multiplier.
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    mul_op_e          op;
  } mul_meta_t;

  // CDB layout: {valid, tag[TAG_W-1:0], value[dw-1:0]}
  function automatic int cdb_w(input int dw);
    return dw + TAG_W + 1;
  endfunction

  function automatic int cdb_tag_lsb(input int dw);
    return dw;
  endfunction

  function automatic int cdb_vld_bit(input int dw);
    return dw + TAG_W;
  endfunction

endpackage

// File: rtl/unit_mul_rs_if.sv
// Issue port, CDB snoop input and CDB request/grant output of the multiply unit.
interface unit_mul_rs_if #(parameter int DATA_W = 32);
  import tomasulo_pkg::*;

  logic                        issue;
  logic [1:0]                  op_in;
  logic [TAG_W-1:0]            q1_in, q2_in;
  logic [DATA_W-1:0]           v1_in, v2_in;
  logic [cdb_w(DATA_W)-1:0]    cdb;
  logic                        all_busy;
  logic [TAG_W-1:0]            issue_tag;
  logic                        cdb_request;
  logic                        cdb_grant;
  logic [DATA_W+TAG_W-1:0]     cdb_out;

  modport master (
    output issue, op_in, q1_in, q2_in, v1_in, v2_in, cdb, cdb_grant,
    input  all_busy, issue_tag, cdb_request, cdb_out
  );

  modport slave (
    input  issue, op_in, q1_in, q2_in, v1_in, v2_in, cdb, cdb_grant,
    output all_busy, issue_tag, cdb_request, cdb_out
  );

endinterface

// File: rtl/mul_pipe.sv
// LAT-stage stallable multiplier. The full 2*DATA_W product is formed on entry
// and carried down the pipe with its tag and op; the half is picked at the end.
module mul_pipe import tomasulo_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int LAT    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_adv,
  input  logic              i_vld,
  input  logic [TAG_W-1:0]  i_tag,
  input  mul_op_e           i_op,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic              o_vld,
  output logic [TAG_W-1:0]  o_tag,
  output logic [DATA_W-1:0] o_res
);

  localparam int PW = 2 * DATA_W;

  logic                     w_sext;
  logic [PW-1:0]            w_a_ext, w_b_ext, w_prod;
  logic [LAT-1:0]           r_vld_pipe;
  mul_meta_t [LAT-1:0]      r_meta;
  logic [LAT-1:0][PW-1:0]   r_prod;

  // Sign-extend only for MULH; the product modulo 2^PW is then exact for both.
  always_comb begin
    w_sext  = (i_op == OP_MULH);
    w_a_ext = {{DATA_W{w_sext & i_a[DATA_W-1]}}, i_a};
    w_b_ext = {{DATA_W{w_sext & i_b[DATA_W-1]}}, i_b};
    w_prod  = w_a_ext * w_b_ext;
  end

  // Valid shift register; every stage holds when the pipe cannot advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_pipe <= '0;
    end else if (i_adv) begin
      r_vld_pipe[0] <= i_vld;
      for (int s = 1; s < LAT; s++) r_vld_pipe[s] <= r_vld_pipe[s-1];
    end
  end

  // Data stages move in lockstep with the valid bits.
  always_ff @(posedge clk) begin
    if (i_adv) begin
      r_meta[0] <= '{tag: i_tag, op: i_op};
      r_prod[0] <= w_prod;
      for (int s = 1; s < LAT; s++) begin
        r_meta[s] <= r_meta[s-1];
        r_prod[s] <= r_prod[s-1];
      end
    end
  end

  // Half select at the tail: high half for MULH/MULHU, low half otherwise.
  always_comb begin
    o_vld = r_vld_pipe[LAT-1];
    o_tag = r_meta[LAT-1].tag;
    if (r_meta[LAT-1].op == OP_MULH || r_meta[LAT-1].op == OP_MULHU)
      o_res = r_prod[LAT-1][PW-1:DATA_W];
    else
      o_res = r_prod[LAT-1][DATA_W-1:0];
  end

endmodule

// File: rtl/unit_mul_rs.sv
// Multiply functional unit: ENTRIES-deep reservation station with CDB snooping,
// oldest-ready-first dispatch into mul_pipe, and a one-entry output register
// that requests the CDB and holds its result until granted.
module unit_mul_rs import tomasulo_pkg::*; #(
  parameter int                   DATA_W  = 32,
  parameter logic [UNIT_ID_W-1:0] UNIT_ID = UID_MUL,
  parameter int                   ENTRIES = 4,
  parameter int                   LAT     = 3
) (
  input logic          clk,
  input logic          rst,
  unit_mul_rs_if.slave bus
);

  localparam int VLD_BIT = cdb_vld_bit(DATA_W);
  localparam int TAG_LSB = cdb_tag_lsb(DATA_W);

  // Entry state
  logic [ENTRIES-1:0]                r_busy, r_disp;
  mul_op_e [ENTRIES-1:0]             r_op;
  logic [ENTRIES-1:0][TAG_W-1:0]     r_q1, r_q2;
  logic [ENTRIES-1:0][DATA_W-1:0]    r_v1, r_v2;
  // r_older[i][j] = entry i was allocated before entry j
  logic [ENTRIES-1:0][ENTRIES-1:0]   r_older;

  // Output register
  logic                r_out_vld;
  logic [TAG_W-1:0]    r_out_tag;
  logic [DATA_W-1:0]   r_out_val;

  logic                w_cdb_vld;
  logic [TAG_W-1:0]    w_cdb_tag;
  logic [DATA_W-1:0]   w_cdb_val;
  logic                w_all_busy, w_alloc, w_hit1, w_hit2;
  logic [IDX_W-1:0]    w_alloc_idx;
  logic [ENTRIES-1:0]  w_rdy, w_sel;
  logic                w_adv, w_fire, w_free;
  logic [DATA_W-1:0]   w_d_a, w_d_b;
  mul_op_e             w_d_op;
  logic [TAG_W-1:0]    w_d_tag;
  logic                w_p_vld;
  logic [TAG_W-1:0]    w_p_tag;
  logic [DATA_W-1:0]   w_p_res;

  assign w_cdb_vld = bus.cdb[VLD_BIT];
  assign w_cdb_tag = bus.cdb[TAG_LSB +: TAG_W];
  assign w_cdb_val = bus.cdb[DATA_W-1:0];

  // Lowest-index free entry, from registered busy bits only.
  always_comb begin
    w_alloc_idx = '0;
    for (int k = ENTRIES-1; k >= 0; k--)
      if (!r_busy[k]) w_alloc_idx = IDX_W'(k);
  end

  assign w_all_busy    = &r_busy;
  assign w_alloc       = bus.issue & ~w_all_busy;
  assign bus.all_busy  = w_all_busy;
  assign bus.issue_tag = w_all_busy ? '0 : {UNIT_ID, w_alloc_idx + IDX_W'(1)};

  // Operand broadcast in the issue cycle is captured straight into the entry.
  assign w_hit1 = w_cdb_vld & (bus.q1_in != '0) & (w_cdb_tag == bus.q1_in);
  assign w_hit2 = w_cdb_vld & (bus.q2_in != '0) & (w_cdb_tag == bus.q2_in);

  // Ready entries, then keep only the one older than every other ready entry.
  always_comb begin
    w_rdy = '0;
    w_sel = '0;
    for (int k = 0; k < ENTRIES; k++)
      w_rdy[k] = r_busy[k] & ~r_disp[k] & (r_q1[k] == '0) & (r_q2[k] == '0);
    for (int i = 0; i < ENTRIES; i++) begin
      w_sel[i] = w_rdy[i];
      for (int j = 0; j < ENTRIES; j++)
        if (w_rdy[j] && !(r_older[i][j] || i == j)) w_sel[i] = 1'b0;
    end
  end

  // Operand mux for the selected (one-hot) entry.
  always_comb begin
    w_d_a   = '0;
    w_d_b   = '0;
    w_d_op  = OP_MUL;
    w_d_tag = '0;
    for (int k = 0; k < ENTRIES; k++) begin
      if (w_sel[k]) begin
        w_d_a   = r_v1[k];
        w_d_b   = r_v2[k];
        w_d_op  = r_op[k];
        w_d_tag = {UNIT_ID, IDX_W'(k + 1)};
      end
    end
  end

  // The whole pipe moves only when the output register can take a result.
  assign w_adv  = ~r_out_vld | bus.cdb_grant;
  assign w_free = r_out_vld & bus.cdb_grant;
  assign w_fire = w_adv & (|w_sel);

  // Entry control: free on grant, allocate on issue, mark dispatched.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
      r_disp <= '0;
    end else begin
      for (int k = 0; k < ENTRIES; k++) begin
        if (w_free && r_out_tag[IDX_W-1:0] == IDX_W'(k + 1)) begin
          r_busy[k] <= 1'b0;
          r_disp[k] <= 1'b0;
        end else if (w_alloc && w_alloc_idx == IDX_W'(k)) begin
          r_busy[k] <= 1'b1;
          r_disp[k] <= 1'b0;
        end else if (w_fire && w_sel[k]) begin
          r_disp[k] <= 1'b1;
        end
      end
    end
  end

  // Entry operands: load on allocate, otherwise snoop the CDB for pending tags.
  always_ff @(posedge clk) begin
    for (int k = 0; k < ENTRIES; k++) begin
      if (w_alloc && w_alloc_idx == IDX_W'(k)) begin
        r_op[k] <= mul_op_e'(bus.op_in);
        r_q1[k] <= w_hit1 ? '0 : bus.q1_in;
        r_v1[k] <= w_hit1 ? w_cdb_val : bus.v1_in;
        r_q2[k] <= w_hit2 ? '0 : bus.q2_in;
        r_v2[k] <= w_hit2 ? w_cdb_val : bus.v2_in;
      end else if (r_busy[k]) begin
        if (w_cdb_vld && r_q1[k] != '0 && w_cdb_tag == r_q1[k]) begin
          r_q1[k] <= '0;
          r_v1[k] <= w_cdb_val;
        end
        if (w_cdb_vld && r_q2[k] != '0 && w_cdb_tag == r_q2[k]) begin
          r_q2[k] <= '0;
          r_v2[k] <= w_cdb_val;
        end
      end
    end
  end

  // Age matrix: a new entry is younger than all others. A freed entry needs no
  // update since its row/column are rewritten when it is next allocated.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_older <= '0;
    end else if (w_alloc) begin
      for (int i = 0; i < ENTRIES; i++)
        for (int j = 0; j < ENTRIES; j++)
          if (IDX_W'(i) == w_alloc_idx)      r_older[i][j] <= 1'b0;
          else if (IDX_W'(j) == w_alloc_idx) r_older[i][j] <= 1'b1;
    end
  end

  mul_pipe #(.DATA_W(DATA_W), .LAT(LAT)) u_pipe (
    .clk   (clk),
    .rst   (rst),
    .i_adv (w_adv),
    .i_vld (w_fire),
    .i_tag (w_d_tag),
    .i_op  (w_d_op),
    .i_a   (w_d_a),
    .i_b   (w_d_b),
    .o_vld (w_p_vld),
    .o_tag (w_p_tag),
    .o_res (w_p_res)
  );

  // Output register: reload from the pipe tail when empty or granted, else hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_vld <= 1'b0;
      r_out_tag <= '0;
      r_out_val <= '0;
    end else if (w_adv) begin
      r_out_vld <= w_p_vld;
      if (w_p_vld) begin
        r_out_tag <= w_p_tag;
        r_out_val <= w_p_res;
      end
    end
  end

  assign bus.cdb_request = r_out_vld;
  assign bus.cdb_out     = {r_out_tag, r_out_val};

endmodule

// File: tb/tb_unit_mul_rs.sv
// Directed bench for unit_mul_rs: latency, dependency wake-up, same-cycle
// capture, multiply modes, back-pressure, and reset mid-flight.
module tb_unit_mul_rs;
  import tomasulo_pkg::*;

  localparam int DATA_W  = 32;
  localparam int ENTRIES = 4;
  localparam int LAT     = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  unit_mul_rs_if #(.DATA_W(DATA_W)) bus ();

  unit_mul_rs #(
    .DATA_W (DATA_W),
    .UNIT_ID(5'b01000),
    .ENTRIES(ENTRIES),
    .LAT    (LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  // Advance n edges and sample 1 time unit after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_issue(input logic [1:0] op, input logic [7:0] q1, input logic [31:0] v1,
                          input logic [7:0] q2, input logic [31:0] v2);
    bus.issue = 1'b1;
    bus.op_in = op;
    bus.q1_in = q1;
    bus.v1_in = v1;
    bus.q2_in = q2;
    bus.v2_in = v2;
    tick(1);
    bus.issue = 1'b0;
  endtask

  // No request for edges-1 edges, then the expected result on the next one.
  task automatic run_to_result(input string name, input int edges, input logic [39:0] exp);
    tick(edges - 1);
    chk({name, "_early"}, 64'(bus.cdb_request), 64'd0);
    tick(1);
    chk({name, "_req"}, 64'(bus.cdb_request), 64'd1);
    chk({name, "_out"}, 64'(bus.cdb_out), 64'(exp));
  endtask

  initial begin
    bus.issue = 1'b0; bus.op_in = '0;
    bus.q1_in = '0; bus.q2_in = '0; bus.v1_in = '0; bus.v2_in = '0;
    bus.cdb = '0; bus.cdb_grant = 1'b0;

    // Reset state
    tick(3);
    chk("rst_all_busy", 64'(bus.all_busy), 64'd0);
    chk("rst_issue_tag", 64'(bus.issue_tag), 64'h41);
    chk("rst_req", 64'(bus.cdb_request), 64'd0);
    chk("rst_out", 64'(bus.cdb_out), 64'd0);
    rst = 1'b0;
    tick(1);

    // Independent MUL 2*3, grant held high
    bus.cdb_grant = 1'b1;
    do_issue(2'b00, 8'h00, 32'd2, 8'h00, 32'd3);
    chk("t1_tag_after_issue", 64'(bus.issue_tag), 64'h42);
    run_to_result("t1", LAT + 1, {8'h41, 32'd6});
    chk("t1_busy_while_req", 64'(bus.issue_tag), 64'h42);
    tick(1);
    chk("t1_freed", 64'(bus.issue_tag), 64'h41);
    chk("t1_req_gone", 64'(bus.cdb_request), 64'd0);

    // Dependency: entry 1 waits on foreign tag 8'h30, entry 2 on tag 8'h41
    do_issue(2'b00, 8'h30, 32'd0, 8'h00, 32'd5);
    do_issue(2'b00, 8'h41, 32'd0, 8'h00, 32'd2);
    chk("t2_tag_two_busy", 64'(bus.issue_tag), 64'h43);
    tick(4);
    chk("t2_no_early_req", 64'(bus.cdb_request), 64'd0);
    bus.cdb = {1'b1, 8'h41, 32'd7};
    tick(1);
    bus.cdb = '0;
    run_to_result("t2_dep", LAT + 1, {8'h42, 32'd14});
    tick(1);
    chk("t2_entry2_freed", 64'(bus.issue_tag), 64'h42);
    // Wake entry 1 while issuing into entry 2 in the same cycle; older goes first
    bus.cdb = {1'b1, 8'h30, 32'd9};
    do_issue(2'b00, 8'h00, 32'd6, 8'h00, 32'd6);
    bus.cdb = '0;
    run_to_result("t2_wake", LAT + 1, {8'h41, 32'd45});
    tick(1);
    chk("t2_second_req", 64'(bus.cdb_request), 64'd1);
    chk("t2_second_out", 64'(bus.cdb_out), 64'({8'h42, 32'd36}));
    tick(1);
    chk("t2_all_free", 64'(bus.issue_tag), 64'h41);

    // Same-cycle capture of an operand broadcast during issue
    bus.cdb = {1'b1, 8'h22, 32'd5};
    do_issue(2'b00, 8'h22, 32'd0, 8'h00, 32'd4);
    bus.cdb = '0;
    run_to_result("t3_capture", LAT + 1, {8'h41, 32'd20});
    tick(1);

    // Modes on 0xFFFFFFFF * 2, issued back to back
    do_issue(2'b01, 8'h00, 32'hFFFF_FFFF, 8'h00, 32'd2);
    do_issue(2'b10, 8'h00, 32'hFFFF_FFFF, 8'h00, 32'd2);
    do_issue(2'b00, 8'h00, 32'hFFFF_FFFF, 8'h00, 32'd2);
    tick(LAT - 1);
    chk("t4_mulh", 64'(bus.cdb_out), 64'({8'h41, 32'hFFFF_FFFF}));
    tick(1);
    chk("t4_mulhu", 64'(bus.cdb_out), 64'({8'h42, 32'h0000_0001}));
    tick(1);
    chk("t4_mul_req", 64'(bus.cdb_request), 64'd1);
    chk("t4_mul", 64'(bus.cdb_out), 64'({8'h43, 32'hFFFF_FFFE}));
    tick(1);
    chk("t4_drained", 64'(bus.cdb_request), 64'd0);
    do_issue(2'b11, 8'h00, 32'd7, 8'h00, 32'd6);
    run_to_result("t4_op11", LAT + 1, {8'h41, 32'd42});
    tick(1);

    // Back-pressure: fill all entries with grant low
    bus.cdb_grant = 1'b0;
    for (int k = 0; k < ENTRIES; k++)
      do_issue(2'b00, 8'h00, 32'(k + 1), 8'h00, 32'd10);
    chk("t5_all_busy", 64'(bus.all_busy), 64'd1);
    chk("t5_tag_zero", 64'(bus.issue_tag), 64'd0);
    do_issue(2'b00, 8'h00, 32'd99, 8'h00, 32'd99);
    tick(5);
    chk("t5_hold_req", 64'(bus.cdb_request), 64'd1);
    chk("t5_hold_out_a", 64'(bus.cdb_out), 64'({8'h41, 32'd10}));
    tick(5);
    chk("t5_hold_out_b", 64'(bus.cdb_out), 64'({8'h41, 32'd10}));
    chk("t5_still_full", 64'(bus.all_busy), 64'd1);
    bus.cdb_grant = 1'b1;
    tick(1);
    chk("t5_r2", 64'(bus.cdb_out), 64'({8'h42, 32'd20}));
    chk("t5_not_full", 64'(bus.all_busy), 64'd0);
    chk("t5_free_tag", 64'(bus.issue_tag), 64'h41);
    tick(1);
    chk("t5_r3", 64'(bus.cdb_out), 64'({8'h43, 32'd30}));
    tick(1);
    chk("t5_r4_req", 64'(bus.cdb_request), 64'd1);
    chk("t5_r4", 64'(bus.cdb_out), 64'({8'h44, 32'd40}));
    tick(1);
    chk("t5_empty", 64'(bus.cdb_request), 64'd0);
    tick(LAT + 1);
    chk("t5_no_extra", 64'(bus.cdb_request), 64'd0);

    // Reset with two results in flight
    do_issue(2'b00, 8'h00, 32'd3, 8'h00, 32'd3);
    do_issue(2'b00, 8'h00, 32'd4, 8'h00, 32'd4);
    tick(1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("t6_req", 64'(bus.cdb_request), 64'd0);
    chk("t6_all_busy", 64'(bus.all_busy), 64'd0);
    chk("t6_tag", 64'(bus.issue_tag), 64'h41);
    for (int c = 0; c < LAT + 3; c++) begin
      tick(1);
      chk("t6_no_stale", 64'(bus.cdb_request), 64'd0);
    end
    do_issue(2'b00, 8'h00, 32'd3, 8'h00, 32'd7);
    run_to_result("t6_after", LAT + 1, {8'h41, 32'd21});
    tick(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/unit_mul_rs.md
# unit_mul_rs

Parametrised multiply functional unit for the Tomasulo core: an ENTRIES-deep reservation station with CDB snooping and oldest-ready-first dispatch into a stallable LAT-stage multiplier pipeline. It adds high-half multiply modes and a request/grant handshake to `common_data_bus`. Results leave through a one-entry output register that holds until granted. Back-pressure stalls the whole pipeline.

## Interface
- DATA_W, 32, operand/result width
- UNIT_ID, 5'b01000, upper 5 bits of every tag this unit issues
- ENTRIES, 4, reservation-station entries, 1..7
- LAT, 3, multiplier pipeline stages, 1..8

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- issue  in  1  allocate an entry this cycle, ignored when all_busy=1
- op_in  in  2  00 MUL low half, 01 MULH signed×signed high half, 10 MULHU unsigned high half, 11 treated as 00
- q1_in, q2_in  in  8  producer tags; 0 means operand value is valid
- v1_in, v2_in  in  DATA_W  operand values, used when matching q is 0
- cdb  in  DATA_W+9  {valid, tag[7:0], value}, registered bus from `common_data_bus`
- all_busy  out  1  no free entry
- issue_tag  out  8  {UNIT_ID, entry index+1} that an issue this cycle receives; 0 when all_busy
- cdb_request  out  1  output register holds a result
- cdb_grant  in  1  bus accepts cdb_out this cycle
- cdb_out  out  DATA_W+8  {tag, value}

## Operation
- Entry state: busy, dispatched, op, q1, q2, v1, v2, age. Entry k uses tag {UNIT_ID, k+1}. Tag 0 is never issued.
- Allocation: on issue & !all_busy, the lowest-index free entry is written at the edge. all_busy and issue_tag come combinationally from registered busy bits only.
- Snoop: every cycle, each busy entry with q≠0 and cdb.valid & cdb.tag==q loads v and clears q. The same snoop applies to q1_in/q2_in on the issue cycle, so an operand broadcast in the issue cycle is captured.
- Ready: busy & !dispatched & q1==0 & q2==0, evaluated on registered state.
- Dispatch: at most one per cycle, oldest ready entry first, using an age matrix updated on allocate/free. It goes when pipeline stage 0 can advance, and sets dispatched. The entry tag travels with the data.
- Arithmetic: full 2·DATA_W product. MUL takes bits [DATA_W-1:0]. MULH sign-extends both operands and takes the upper half. MULHU zero-extends both and takes the upper half.
- Pipeline: each stage holds valid+tag+op+partial. All stages advance when the output register is empty or being granted. Otherwise every stage holds.
- Output: cdb_request = out_valid. cdb_out is stable while request is held without grant. On request&grant at the edge, the entry is freed (busy=0) and the output reloads from the last stage, or goes empty.
- Free takes effect at the edge. An entry freed at edge E can be allocated from cycle E+1.

## Timing
- Reset values: all_busy=0, issue_tag={UNIT_ID,3'd1}, cdb_request=0, cdb_out=0. All busy, dispatched and stage valids clear.
- Uncontended latency: issue with ready operands at edge E0, dispatch at E1, output loaded at E1+LAT, so cdb_request is high in cycle E0+1+LAT.
- Grant in the first request cycle gives one result per cycle throughput when operands are ready.
- Held grant=0: no result is lost or duplicated. The pipeline refills at most LAT results behind the output.
- Full: issue while all_busy is ignored. all_busy falls the cycle after the grant edge.
- Simultaneous snoop and issue on different entries are both handled in the same cycle.
- Reset mid-operation discards all entries, in-flight and held results. No request appears after the rst cycle.

## Structure
- Shared package `tomasulo_pkg`: TAG_W=8, UNIT_ID_W=5, CDB_W, unit ID constants, op encodings, CDB field offsets (valid/tag/value).
- One sub-module `mul_pipe`: LAT-stage stallable multiplier carrying {valid, tag, op}, with an advance input.

## Test plan
- Independent issue, v1=2, v2=3, MUL, grant held high. Required: cdb_out={8'h41,32'd6} in cycle 1+LAT after issue, entry 1 free one cycle later.
- Dependency: issue q1=8'h41, v2=2, then broadcast tag 8'h41 value 7 on cdb. Required: result {8'h42,32'd14}, dispatched the cycle after the broadcast.
- Same-cycle capture: issue q1=8'h22 while cdb carries {1,8'h22,5}, v2=4. Required: result 20.
- Modes: 0xFFFFFFFF×2. MULH must give 0xFFFFFFFF, MULHU must give 0x00000001, MUL must give 0xFFFFFFFE.
- Back-pressure: fill all 4 entries, grant low for 10 cycles, then grant high. Required: all_busy=1, and cdb_out frozen with the oldest result while grant is low. After release, 4 in-order results on consecutive cycles, and all_busy drops after the first grant.
- Reset mid-flight: rst with 2 entries in pipeline. Required: cdb_request=0 and all_busy=0 next cycle, and no stale result appears afterwards.
